seg7_scan_mux: RTL and testbench

//  Time-multiplexed driver for an N-digit common-anode 7-segment display.

---
 rtl/seg7_pkg.sv | 19 +
 rtl/seg7_scan_mux_prescaler.sv | 50 +++++
 rtl/seg7_scan_mux.sv | 127 ++++++++++++
 tb/tb_seg7_scan_mux.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and helpers for the seven-segment scan driver.
package seg7_pkg;

  localparam logic [7:0] SEG_BLANK  = 8'hFF;
  localparam int         MAX_DIGITS = 32;

  typedef enum logic {
    ST_IDLE,
    ST_SCAN
  } state_t;

  // Active-low one-hot anode select; callers keep the low NUM_DIGITS bits.
  function automatic logic [MAX_DIGITS-1:0] anode_on(
    input logic [31:0] idx
  );
    anode_on = ~(MAX_DIGITS'(1) << idx);
  endfunction

endpackage

// File: rtl/seg7_scan_mux_prescaler.sv
// Slot/digit position counters for the scan driver.
module scan_prescaler #(
  parameter int NUM_DIGITS = 4,
  parameter int DIV        = 50000,
  parameter int CW         = 16,
  parameter int DW         = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          en,
  output logic [CW-1:0] cnt_nxt,
  output logic [DW-1:0] digit_nxt,
  output logic          slot_end,
  output logic          frame_end
);

  logic [CW-1:0] cnt;
  logic [DW-1:0] digit;

  assign slot_end  = (cnt == CW'(DIV - 1));
  assign frame_end = slot_end && (digit == DW'(NUM_DIGITS - 1));

  always_comb begin
    cnt_nxt   = cnt;
    digit_nxt = digit;
    if (clear) begin
      cnt_nxt   = '0;
      digit_nxt = '0;
    end else if (en) begin
      if (slot_end) begin
        cnt_nxt   = '0;
        digit_nxt = frame_end ? '0 : digit + DW'(1);
      end else begin
        cnt_nxt = cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      digit <= '0;
    end else begin
      cnt   <= cnt_nxt;
      digit <= digit_nxt;
    end
  end

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed common-anode 7-segment driver with blanking guard
// and frame-aligned (tear-free) pattern capture.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DIV        = 50000,
  parameter int BLANK      = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    update,
  input  logic [8*NUM_DIGITS-1:0] seg_in,
  output logic [7:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    frame_tick
);

  localparam int CW = $clog2(DIV);
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  state_t state, state_nxt;

  logic [NUM_DIGITS-1:0][7:0] shadow, shadow_d;
  logic [NUM_DIGITS-1:0][7:0] stage, stage_d;
  logic                       pending, pending_d;

  logic [CW-1:0]         cnt_nxt;
  logic [DW-1:0]         digit_nxt;
  logic                  slot_end, frame_end;
  logic                  boundary;
  logic [MAX_DIGITS-1:0] an_full;

  logic [7:0]            seg_d;
  logic [NUM_DIGITS-1:0] an_d;
  logic                  tick_d;

  scan_prescaler #(
    .NUM_DIGITS(NUM_DIGITS),
    .DIV       (DIV),
    .CW        (CW),
    .DW        (DW)
  ) u_pre (
    .clk      (clk),
    .reset    (reset),
    .clear    ((state == ST_IDLE) || !enable),
    .en       (state == ST_SCAN),
    .cnt_nxt  (cnt_nxt),
    .digit_nxt(digit_nxt),
    .slot_end (slot_end),
    .frame_end(frame_end)
  );

  assign boundary = (state == ST_SCAN) && enable
                 && slot_end && frame_end;

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (enable)  state_nxt = ST_SCAN;
      ST_SCAN: if (!enable) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    shadow_d  = shadow;
    stage_d   = stage;
    pending_d = pending;
    unique case (1'b1)
      (state == ST_IDLE): begin
        if (update) shadow_d = seg_in;
      end
      boundary: begin
        if (update) begin
          shadow_d  = seg_in;
          pending_d = 1'b0;
        end else if (pending) begin
          shadow_d  = stage;
          pending_d = 1'b0;
        end
      end
      default: begin
        if (update) begin
          stage_d   = seg_in;
          pending_d = 1'b1;
        end
      end
    endcase
  end

  // Outputs are registered from the position the counters move to.
  always_comb begin
    seg_d   = SEG_BLANK;
    an_d    = '1;
    an_full = anode_on(32'(digit_nxt));
    tick_d  = enable
           && (cnt_nxt == CW'(DIV - 1))
           && (digit_nxt == DW'(NUM_DIGITS - 1));
    if (enable && (cnt_nxt >= CW'(BLANK))) begin
      an_d  = an_full[NUM_DIGITS-1:0];
      seg_d = shadow_d[digit_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      shadow     <= {NUM_DIGITS{SEG_BLANK}};
      stage      <= {NUM_DIGITS{SEG_BLANK}};
      pending    <= 1'b0;
      seg_out    <= SEG_BLANK;
      an_out     <= '1;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_nxt;
      shadow     <= shadow_d;
      stage      <= stage_d;
      pending    <= pending_d;
      seg_out    <= seg_d;
      an_out     <= an_d;
      frame_tick <= tick_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Scoreboard bench for seg7_scan_mux (NUM_DIGITS=4, DIV=8, BLANK=2).
module tb_seg7_scan_mux;

  typedef struct packed {
    logic [7:0] seg;
    logic [3:0] an;
    logic       tick;
  } exp_t;

  localparam exp_t DARK = '{seg: 8'hFF, an: 4'hF, tick: 1'b0};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        update = 1'b0;
  logic [31:0] seg_in = '0;
  logic [7:0]  seg_out;
  logic [3:0]  an_out;
  logic        frame_tick;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit done     = 1'b0;
  exp_t q[$];

  seg7_scan_mux #(
    .NUM_DIGITS(4),
    .DIV       (8),
    .BLANK     (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .update    (update),
    .seg_in    (seg_in),
    .seg_out   (seg_out),
    .an_out    (an_out),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic drive(
    input bit r, input bit en, input bit upd,
    input logic [31:0] sin, input exp_t e
  );
    @(negedge clk);
    reset  = r;
    enable = en;
    update = upd;
    seg_in = sin;
    q.push_back(e);
  endtask

  // Expected outputs at scan position k, given the displayed patterns p.
  task automatic scan(
    input int k, input bit upd,
    input logic [31:0] sin, input logic [31:0] p
  );
    int   c;
    int   d;
    exp_t e;
    c = k % 8;
    d = (k / 8) % 4;
    e = DARK;
    if (c >= 2) begin
      e.seg = p[d*8 +: 8];
      e.an  = ~(4'b0001 << d);
    end
    e.tick = ((k % 32) == 31);
    drive(1'b0, 1'b1, upd, sin, e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        checks++;
        if ({seg_out, an_out, frame_tick} !== e) begin
          failures++;
          $display("FAIL out[%0d]: seg=%h an=%b tick=%b required seg=%h an=%b tick=%b",
                   cyc, seg_out, an_out, frame_tick, e.seg, e.an, e.tick);
        end
        cyc++;
      end
    end
  end

  initial begin : watchdog
    #200000;
    if (!done) begin
      $display("FAIL watchdog: checks=%0d required completion", checks);
      $fatal(1, "timeout");
    end
  end

  initial begin : stim
    // reset dominates any enable/update
    for (int i = 0; i < 5; i++)
      drive(1'b1, 1'($urandom % 2), 1'($urandom % 2), $urandom, DARK);

    // idle capture, then frame 0 with mid-frame update at position 12
    drive(1'b0, 1'b0, 1'b1, 32'hF9A4B0C0, DARK);
    for (int k = 0; k < 48; k++)
      scan(k, k == 12, 32'h99999999,
           (k < 32) ? 32'hF9A4B0C0 : 32'h99999999);

    // enable dropped at edge 13, then restart
    drive(1'b0, 1'b0, 1'b0, '0, DARK);
    for (int k = 0; k < 13; k++)
      scan(k, 1'b0, '0, 32'h99999999);
    for (int i = 0; i < 3; i++)
      drive(1'b0, 1'b0, 1'b0, '0, DARK);
    for (int k = 0; k < 11; k++)
      scan(k, 1'b0, '0, 32'h99999999);

    // pending 11.. overridden by fresh 22.. on the frame-boundary edge
    drive(1'b0, 1'b0, 1'b0, '0, DARK);
    for (int k = 0; k < 72; k++)
      scan(k, (k == 5) || (k == 32),
           (k == 5) ? 32'h11111111 : 32'h22222222,
           (k < 32) ? 32'h99999999 : 32'h22222222);

    // reset mid-frame discards shadow, stage and pending
    drive(1'b0, 1'b0, 1'b0, '0, DARK);
    for (int k = 0; k < 20; k++)
      scan(k, k == 10, 32'h33333333, 32'h22222222);
    drive(1'b1, 1'b1, 1'b0, '0, DARK);
    for (int k = 0; k < 40; k++)
      scan(k, 1'b0, '0, 32'hFFFFFFFF);
    drive(1'b0, 1'b0, 1'b0, '0, DARK);

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: pending=%0d required 0", q.size());
    end
    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
